// File: rtl/apb_rr_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_rr_master_arbiter_if
//   APB bus bundle between the round-robin APB master and the slave decoder.
//
//   Signals:
//     psel, penable, pwrite  APB control (driven by the master)
//     paddr                  APB address (driven by the master)
//     pwdata                 APB write data (driven by the master)
//     prdata                 APB read data (driven by the slave)
//     pready                 APB ready (driven by the slave)
//     pslverr                APB slave error (driven by the slave)
//
//   Modports: master (the arbiter), slave (peripheral side / decoder).
// ---------------------------------------------------------------------------
interface apb_rr_master_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_master_arbiter
//   Two-requester round-robin APB master. Each requester holds reqN high
//   until its one-cycle doneN pulse; the arbiter runs the APB SETUP/ACCESS
//   sequence (with wait states) for the winner and returns rdata/err
//   alongside the done pulse. All outputs are registered.
//
//   Ports:
//     hclk, hresetn          clock, asynchronous active-low reset
//     req0/1, wr0/1          request and direction (1 = write) per requester
//     addr0/1, wdata0/1      address and write data per requester
//     done0/1                one-cycle completion pulse per requester
//     rdata, err             read data / error, valid while a done is high
//     apb                    APB bus (master modport)
//
//   Optional feature: define APB_RR_ARB_TIMEOUT_EN to terminate an ACCESS
//   phase that sees pready low for TIMEOUT cycles (done with err=1, rdata=0).
//   Without the macro ACCESS waits indefinitely for pready.
// ---------------------------------------------------------------------------
module apb_rr_master_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    wr0,
    input  logic                    wr1,
    input  logic [ADDR_W-1:0]       addr0,
    input  logic [ADDR_W-1:0]       addr1,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic [DATA_W-1:0]       wdata1,
    output logic                    done0,
    output logic                    done1,
    output logic [DATA_W-1:0]       rdata,
    output logic                    err,
    apb_rr_master_arbiter_if.master apb
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cur_id_q, cur_id_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              valid0, valid1, winner;

`ifdef APB_RR_ARB_TIMEOUT_EN
    logic [7:0]        wait_cnt_q, wait_cnt_d;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;  // req0 wins the first contention
            cur_id_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

`ifdef APB_RR_ARB_TIMEOUT_EN
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // A requester whose done pulse is visible this cycle has just been served;
    // its request line is still high, so it must not be reissued.
    assign valid0 = req0 & ~done0_q;
    assign valid1 = req1 & ~done1_q;
    assign winner = (valid0 & valid1) ? ~last_grant_q : valid1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef APB_RR_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (valid0 | valid1) begin
                    state_d      = StSetup;
                    cur_id_d     = winner;
                    last_grant_d = winner;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    pwrite_d     = winner ? wr1 : wr0;
                    paddr_d      = winner ? addr1 : addr0;
                    pwdata_d     = winner ? wdata1 : wdata0;
                end
            end

            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
`ifdef APB_RR_ARB_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
            end

            StAccess: begin
                if (apb.pready) begin
                    state_d   = StIdle;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = pwrite_q ? '0 : apb.prdata;
                    err_d     = apb.pslverr;
                    done0_d   = ~cur_id_q;
                    done1_d   = cur_id_q;
`ifdef APB_RR_ARB_TIMEOUT_EN
                end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled ACCESS cycle: give up.
                    state_d   = StIdle;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    done0_d   = ~cur_id_q;
                    done1_d   = cur_id_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;

    assign done0 = done0_q;
    assign done1 = done1_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master_arbiter
//   Self-checking bench for apb_rr_master_arbiter. A scoreboard queue holds
//   the expected completion of every transfer in grant order; each done pulse
//   pops one entry and compares id, rdata, err and the held APB fields.
//   A small APB slave model answers ACCESS after wait_cfg stalled cycles.
//   With APB_RR_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT=4 and
//   the timeout scenario is exercised as well.
// ---------------------------------------------------------------------------
module tb_apb_rr_master_arbiter;

`ifdef APB_RR_ARB_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
`else
    localparam int unsigned TbTimeout = 16;
`endif

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1;
    logic [31:0] rdata;
    logic        err;

    apb_rr_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_rr_master_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TbTimeout)
    ) dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .req0   (req0),
        .req1   (req1),
        .wr0    (wr0),
        .wr1    (wr1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .done0  (done0),
        .done1  (done1),
        .rdata  (rdata),
        .err    (err),
        .apb    (bus)
    );

    always #5 hclk = ~hclk;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic sb_push(input logic id, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [31:0] rd, input logic e);
        exp_t x;
        x.id = id; x.addr = addr; x.wr = wr; x.wdata = wdata; x.rdata = rd; x.err = e;
        sb.push_back(x);
    endtask

    always @(negedge hclk) begin
        if (hresetn && (done0 || done1)) begin
            check_eq("done_onehot", 32'(done0 & done1), 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check_eq("sb_id",     32'(done1),      32'(x.id));
                check_eq("sb_rdata",  rdata,           x.rdata);
                check_eq("sb_err",    32'(err),        32'(x.err));
                check_eq("sb_paddr",  bus.paddr,       x.addr);
                check_eq("sb_pwrite", 32'(bus.pwrite), 32'(x.wr));
                check_eq("sb_pwdata", bus.pwdata,      x.wdata);
            end
        end
    end

    // ---------------- APB slave model ----------------
    int          wait_cfg;
    logic [31:0] rd_cfg;
    logic        err_cfg;
    int          acc_cnt = 0;

    always @(negedge hclk) begin
        if (bus.psel && bus.penable) begin
            bus.pready  = (acc_cnt >= wait_cfg);
            bus.pslverr = (acc_cnt >= wait_cfg) ? err_cfg : 1'b0;
            bus.prdata  = rd_cfg;
            acc_cnt++;
        end else begin
            acc_cnt     = 0;
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prdata  = 32'h0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int   pen_cnt;
    logic psel_at_done;

    // Wait for n0 done0 and n1 done1 pulses, dropping each request after its
    // last pulse. Bounded by budget cycles.
    task automatic serve(input int n0, input int n1, input int budget);
        int r0 = n0;
        int r1 = n1;
        int cyc = 0;
        pen_cnt = 0;
        psel_at_done = 1'b1;
        while ((r0 > 0 || r1 > 0) && cyc < budget) begin
            @(negedge hclk);
            cyc++;
            if (bus.psel && bus.penable) pen_cnt++;
            if (done0) begin
                r0--;
                psel_at_done = bus.psel;
                if (r0 <= 0) req0 = 1'b0;
            end
            if (done1) begin
                r1--;
                psel_at_done = bus.psel;
                if (r1 <= 0) req1 = 1'b0;
            end
        end
        check_eq("serve_complete", 32'(r0 > 0 || r1 > 0), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        hresetn = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        wait_cfg = 0; rd_cfg = '0; err_cfg = 1'b0;

        #1;
        check_eq("rst_psel",    32'(bus.psel),    32'd0);
        check_eq("rst_penable", 32'(bus.penable), 32'd0);
        check_eq("rst_pwrite",  32'(bus.pwrite),  32'd0);
        check_eq("rst_paddr",   bus.paddr,        32'd0);
        check_eq("rst_pwdata",  bus.pwdata,       32'd0);
        check_eq("rst_done",    32'({done0, done1}), 32'd0);
        check_eq("rst_rdata",   rdata,            32'd0);
        check_eq("rst_err",     32'(err),         32'd0);

        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);

        // 1: single read, zero wait states, latency check
        addr0 = 32'h40; wr0 = 1'b0; wdata0 = 32'h0BAD_0040;
        rd_cfg = 32'hDEAD_BEEF; err_cfg = 1'b0; wait_cfg = 0;
        sb_push(1'b0, 32'h40, 1'b0, 32'h0BAD_0040, 32'hDEAD_BEEF, 1'b0);
        req0 = 1'b1;
        @(negedge hclk);
        check_eq("t1_setup_psel",    32'(bus.psel),    32'd1);
        check_eq("t1_setup_penable", 32'(bus.penable), 32'd0);
        @(negedge hclk);
        check_eq("t1_access_psel",    32'(bus.psel),    32'd1);
        check_eq("t1_access_penable", 32'(bus.penable), 32'd1);
        @(negedge hclk);
        check_eq("t1_done0", 32'(done0), 32'd1);
        req0 = 1'b0;
        @(negedge hclk);
        check_eq("t1_done0_pulse", 32'(done0), 32'd0);

        // 2: both requests held from fresh reset -> grants 0,1,0,1
        pulse_reset();
        wr0 = 1'b1; wr1 = 1'b1;
        addr0 = 32'h10; addr1 = 32'h20;
        wdata0 = 32'hA0A0_0010; wdata1 = 32'hB1B1_0020;
        wait_cfg = 0; err_cfg = 1'b0;
        sb_push(1'b0, 32'h10, 1'b1, 32'hA0A0_0010, 32'h0, 1'b0);
        sb_push(1'b1, 32'h20, 1'b1, 32'hB1B1_0020, 32'h0, 1'b0);
        sb_push(1'b0, 32'h10, 1'b1, 32'hA0A0_0010, 32'h0, 1'b0);
        sb_push(1'b1, 32'h20, 1'b1, 32'hB1B1_0020, 32'h0, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        serve(2, 2, 60);
        check_eq("t2_penable_cycles", 32'(pen_cnt), 32'd4);
        @(negedge hclk);

        // 3: req1 write, 3 wait states, pslverr on completion
        wr1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h1234_5678;
        wait_cfg = 3; err_cfg = 1'b1;
        sb_push(1'b1, 32'h80, 1'b1, 32'h1234_5678, 32'h0, 1'b1);
        req1 = 1'b1;
        serve(0, 1, 60);
        check_eq("t3_penable_cycles", 32'(pen_cnt), 32'd4);
        @(negedge hclk);
        check_eq("t3_done1_once", 32'(done1), 32'd0);
        err_cfg = 1'b0;

`ifdef APB_RR_ARB_TIMEOUT_EN
        // 4: timeout, pready stuck low
        wr0 = 1'b0; addr0 = 32'h44; wdata0 = 32'h0000_0044;
        wait_cfg = 1000; rd_cfg = 32'hFFFF_FFFF;
        sb_push(1'b0, 32'h44, 1'b0, 32'h0000_0044, 32'h0, 1'b1);
        req0 = 1'b1;
        serve(1, 0, 60);
        check_eq("t4_access_cycles", 32'(pen_cnt), 32'd4);
        check_eq("t4_psel_after", 32'(psel_at_done), 32'd0);
        @(negedge hclk);
`endif

        // 5: reset during ACCESS of a req1 transfer aborts it
        wr1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h0000_3333;
        wait_cfg = 1000;
        req1 = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        check_eq("t5_in_access", 32'(bus.penable), 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        check_eq("t5_async_psel",    32'(bus.psel),    32'd0);
        check_eq("t5_async_penable", 32'(bus.penable), 32'd0);
        check_eq("t5_async_done1",   32'(done1),       32'd0);
        wr0 = 1'b0; addr0 = 32'h50; wdata0 = 32'h0000_5050;
        wait_cfg = 0; rd_cfg = 32'h5555_AAAA;
        req0 = 1'b1;
        sb_push(1'b0, 32'h50, 1'b0, 32'h0000_5050, 32'h5555_AAAA, 1'b0);
        sb_push(1'b1, 32'h30, 1'b1, 32'h0000_3333, 32'h0,         1'b0);
        @(negedge hclk);
        hresetn = 1'b1;
        serve(1, 1, 60);

        repeat (3) @(negedge hclk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/apb_rr_master_arbiter.md
# apb_rr_master_arbiter

Two-requester round-robin APB master that shares one APB peripheral bus between two on-chip initiators, such as the AHB bridge write path and a DMA/config engine. It accepts a held request from either requester, runs the full APB SETUP/ACCESS sequence with wait-state support, and returns read data and error status with a one-cycle completion pulse. It sits directly on the APB side, in front of the slave decoder.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, maximum ACCESS cycles with pready low (only used with the timeout macro); legal range 2..255

Ports:
- hclk  in  1  clock; everything samples on the rising edge
- hresetn  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transfer request; held high until the matching done pulse
- wr0 / wr1  in  1  1 = write, 0 = read; stable while the request is high
- addr0 / addr1  in  ADDR_W  transfer address
- wdata0 / wdata1  in  DATA_W  write data
- done0 / done1  out  1  one-cycle completion pulse to the requester
- rdata  out  DATA_W  read data, valid while done0 or done1 is high
- err  out  1  error status, valid while done0 or done1 is high
- psel, penable, pwrite  out  1  APB control signals
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS, encoded in 2 bits. All outputs are registered.
- IDLE:
  - The arbiter evaluates the valid requests.
  - A requester whose done pulse is high in that same cycle is ignored, so a just-served request is never reissued.
  - If any request is valid, the winner is latched into cur_id and the state moves to SETUP.
- Arbitration is round-robin using a last_grant register.
  - With a single valid request, that requester wins.
  - With both valid, the requester that is not last_grant wins.
  - last_grant updates to the winner on entry to SETUP.
- SETUP (1 cycle):
  - psel=1, penable=0.
  - paddr, pwrite and pwdata hold the winner's addr, wr and wdata, latched on entry.
  - The state always moves to ACCESS.
- ACCESS:
  - psel=1, penable=1, address and data held stable.
  - If pready=1: capture prdata into rdata (reads only; writes drive rdata=0), set err=pslverr, pulse done for cur_id, and move to IDLE.
  - If pready=0: stay in ACCESS.
- On exit from ACCESS, psel=0 and penable=0. paddr, pwrite and pwdata hold their last values.
- Only one of done0/done1 is ever high in a cycle. Each done pulse lasts exactly one cycle.

## Timing
- Reset values (asserted asynchronously while hresetn=0):
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0
  - done0=0, done1=0, rdata=0, err=0
  - state=IDLE, last_grant=1, so req0 wins the first contention
- Reset asserted mid-transfer aborts immediately. No done pulse is generated. The first transfer after release starts from IDLE.
- Latency with zero wait states:
  - A request seen high in IDLE at edge N drives SETUP in cycle N+1 and ACCESS in cycle N+2.
  - The done pulse is in cycle N+3.
  - Back-to-back throughput is one transfer per 3 cycles.
- Each wait state (pready=0 in ACCESS) adds one cycle.
- If a request deasserts before it is granted, it is ignored. Deasserting a granted request mid-transfer is a protocol violation: the transfer completes regardless.
- Simultaneous events:
  - A new request on the other port during ACCESS is held until IDLE.
  - In the IDLE cycle carrying done for port k, only port !k can win.

## Configuration
- Macro: APB_RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on SETUP and increments on each ACCESS cycle with pready=0.
  - If pready is still 0 when the counter reaches TIMEOUT, the transfer is terminated: done for cur_id pulses, err=1, rdata=0, and the state returns to IDLE.
  - A pready=1 in that same cycle wins: the transfer completes normally.
- Undefined: there is no counter, and ACCESS waits indefinitely for pready.

## Test plan
- Reset, then req0 read at addr 0x40 with pready=1 and prdata=0xDEADBEEF:
  - SETUP at +1 and ACCESS at +2.
  - done0 at +3 with rdata=0xDEADBEEF and err=0.
- req0 and req1 raised together and held, both writes to addr 0x10 / 0x20:
  - Grant order is 0, 1, 0, 1.
  - paddr sequence is 0x10, 0x20, 0x10, 0x20, each with pwrite=1 and the matching pwdata.
- req1 write with pready low for 3 ACCESS cycles and pslverr=1 on completion:
  - penable is high for 4 cycles.
  - done1 pulses once, with err=1.
- Timeout (macro defined, TIMEOUT=4), req0 read with pready stuck at 0:
  - 4 ACCESS cycles.
  - done0 with err=1 and rdata=0; psel=0 the next cycle.
- hresetn pulsed low during ACCESS of a req1 transfer:
  - psel, penable and done1 go to 0 asynchronously; no done pulse is generated.
  - After release with both requests high, req0 wins.
